// File: rtl/dual_hbridge_cmd_ctrl.sv
// Command-driven PWM controller for two DC motor channels (A, B) feeding a
// dual H-bridge driver stage.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   estop               emergency stop (level, active-high): forces COAST
//   cmd_valid/cmd_ready command handshake; cmd_ready depends on cmd_ch
//   cmd_ch              target channel (0=A, 1=B)
//   cmd_dir             00=COAST, 01=FWD, 10=REV, 11=BRAKE
//   cmd_duty            high count per PWM period
//   drv_in1..drv_in4    direction lines (A: in1/in2, B: in3/in4)
//   drv_enA, drv_enB    PWM enables
//   busy_a, busy_b      channel is in reversal dead-time
module dual_hbridge_cmd_ctrl #(
    parameter int unsigned PWM_WIDTH = 8,
    parameter int unsigned DEADTIME  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 estop,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_ch,
    input  logic [1:0]           cmd_dir,
    input  logic [PWM_WIDTH-1:0] cmd_duty,
    output logic                 drv_in1,
    output logic                 drv_in2,
    output logic                 drv_in3,
    output logic                 drv_in4,
    output logic                 drv_enA,
    output logic                 drv_enB,
    output logic                 busy_a,
    output logic                 busy_b
);

    localparam int unsigned DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

    typedef enum logic [2:0] {
        ST_COAST,
        ST_FWD,
        ST_REV,
        ST_BRAKE,
        ST_DEAD
    } state_t;

    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_FWD   = 2'b01,
        DIR_REV   = 2'b10,
        DIR_BRAKE = 2'b11
    } dir_t;

    state_t               state_q     [2];
    state_t               state_d     [2];
    logic [PWM_WIDTH-1:0] duty_q      [2];
    logic [PWM_WIDTH-1:0] duty_d      [2];
    logic [PWM_WIDTH-1:0] pend_duty_q [2];
    logic [PWM_WIDTH-1:0] pend_duty_d [2];
    logic                 pend_fwd_q  [2];
    logic                 pend_fwd_d  [2];
    logic [DW-1:0]        dead_q      [2];
    logic [DW-1:0]        dead_d      [2];
    logic                 hi_q        [2];
    logic                 hi_d        [2];
    logic                 lo_q        [2];
    logic                 lo_d        [2];
    logic                 en_q        [2];
    logic                 en_d        [2];
    logic [PWM_WIDTH-1:0] cnt_q;
    logic [PWM_WIDTH-1:0] cnt_d;
    logic [1:0]           busy;
    logic                 accept;
    logic                 wrap;
    dir_t                 dir;

    assign busy[0]   = (state_q[0] == ST_DEAD);
    assign busy[1]   = (state_q[1] == ST_DEAD);
    assign cmd_ready = !estop && !busy[cmd_ch];
    assign accept    = cmd_valid && cmd_ready;
    assign dir       = dir_t'(cmd_dir);

    // State register (includes the registered drive outputs)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                state_q[ch]     <= ST_COAST;
                duty_q[ch]      <= '0;
                pend_duty_q[ch] <= '0;
                pend_fwd_q[ch]  <= 1'b0;
                dead_q[ch]      <= '0;
                hi_q[ch]        <= 1'b0;
                lo_q[ch]        <= 1'b0;
                en_q[ch]        <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                state_q[ch]     <= state_d[ch];
                duty_q[ch]      <= duty_d[ch];
                pend_duty_q[ch] <= pend_duty_d[ch];
                pend_fwd_q[ch]  <= pend_fwd_d[ch];
                dead_q[ch]      <= dead_d[ch];
                hi_q[ch]        <= hi_d[ch];
                lo_q[ch]        <= lo_d[ch];
                en_q[ch]        <= en_d[ch];
            end
        end
    end

    // Next-state logic
    always_comb begin
        logic load_now;
        logic want_fwd;
        logic reversal;
        cnt_d = cnt_q + 1'b1;
        wrap  = (cnt_q == '1);
        for (int unsigned ch = 0; ch < 2; ch++) begin
            state_d[ch]     = state_q[ch];
            duty_d[ch]      = duty_q[ch];
            pend_duty_d[ch] = pend_duty_q[ch];
            pend_fwd_d[ch]  = pend_fwd_q[ch];
            dead_d[ch]      = dead_q[ch];
            load_now        = 1'b0;
            want_fwd        = 1'b0;
            reversal        = 1'b0;
            if (estop) begin
                state_d[ch] = ST_COAST;
            end else if (accept && (cmd_ch == 1'(ch))) begin
                case (dir)
                    DIR_COAST: state_d[ch] = ST_COAST;
                    DIR_BRAKE: state_d[ch] = ST_BRAKE;
                    default: begin
                        want_fwd = (dir == DIR_FWD);
                        reversal = (DEADTIME > 0) &&
                                   (((state_q[ch] == ST_FWD) && !want_fwd) ||
                                    ((state_q[ch] == ST_REV) && want_fwd));
                        pend_duty_d[ch] = cmd_duty;
                        if (reversal) begin
                            state_d[ch]    = ST_DEAD;
                            pend_fwd_d[ch] = want_fwd;
                            dead_d[ch]     = DW'(DEADTIME);
                        end else begin
                            state_d[ch] = want_fwd ? ST_FWD : ST_REV;
                            // Starting from standstill there is no running
                            // waveform to protect, so apply the duty at once.
                            load_now = (state_q[ch] == ST_COAST) ||
                                       (state_q[ch] == ST_BRAKE);
                        end
                    end
                endcase
            end else if (state_q[ch] == ST_DEAD) begin
                // Counter loaded with DEADTIME; leaving on the value 1 gives
                // exactly DEADTIME cycles in DEAD.
                if (dead_q[ch] <= DW'(1)) begin
                    state_d[ch] = pend_fwd_q[ch] ? ST_FWD : ST_REV;
                    load_now    = 1'b1;
                end else begin
                    dead_d[ch] = dead_q[ch] - 1'b1;
                end
            end
            // Duty otherwise changes only at the period boundary so a
            // running PWM period is never cut short or stretched.
            if (load_now || wrap) begin
                duty_d[ch] = pend_duty_d[ch];
            end
        end
    end

    // Output logic
    always_comb begin
        logic pwm_on;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            pwm_on   = (cnt_q < duty_q[ch]);
            hi_d[ch] = 1'b0;
            lo_d[ch] = 1'b0;
            en_d[ch] = 1'b0;
            case (state_q[ch])
                ST_FWD: begin
                    hi_d[ch] = 1'b1;
                    en_d[ch] = pwm_on;
                end
                ST_REV: begin
                    lo_d[ch] = 1'b1;
                    en_d[ch] = pwm_on;
                end
                ST_BRAKE: begin
                    hi_d[ch] = 1'b1;
                    lo_d[ch] = 1'b1;
                    en_d[ch] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign drv_in1 = hi_q[0];
    assign drv_in2 = lo_q[0];
    assign drv_enA = en_q[0];
    assign drv_in3 = hi_q[1];
    assign drv_in4 = lo_q[1];
    assign drv_enB = en_q[1];
    assign busy_a  = busy[0];
    assign busy_b  = busy[1];

endmodule

// File: tb/tb_dual_hbridge_cmd_ctrl.sv
// Testbench for dual_hbridge_cmd_ctrl (PWM_WIDTH=4, DEADTIME=3).
module tb_dual_hbridge_cmd_ctrl;

    localparam int W   = 4;
    localparam int DT  = 3;
    localparam int PER = 2 ** W;

    localparam int M_COAST = 0;
    localparam int M_FWD   = 1;
    localparam int M_REV   = 2;
    localparam int M_BRAKE = 3;
    localparam int M_DEAD  = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         estop     = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ch    = 1'b0;
    logic [1:0]   cmd_dir   = 2'b00;
    logic [W-1:0] cmd_duty  = '0;
    logic         cmd_ready;
    logic         drv_in1, drv_in2, drv_in3, drv_in4, drv_enA, drv_enB;
    logic         busy_a, busy_b;

    always #5 clk = ~clk;

    dual_hbridge_cmd_ctrl #(.PWM_WIDTH(W), .DEADTIME(DT)) dut (
        .clk(clk), .rst(rst), .estop(estop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3),
        .drv_in4(drv_in4), .drv_enA(drv_enA), .drv_enB(drv_enB),
        .busy_a(busy_a), .busy_b(busy_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: channel mode, remaining dead cycles, running and
    // next-period duty, plus the drive pattern expected after each edge.
    int m_mode[2], m_left[2], m_tgt[2], m_duty_now[2], m_duty_next[2];
    int m_cnt;
    bit e_hi[2], e_lo[2], e_en[2];
    bit model_on = 1'b0;

    function automatic void model_step();
        bit boundary, took, loaded;
        int want;
        if (rst) begin
            m_cnt = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_mode[ch] = M_COAST; m_left[ch] = 0; m_tgt[ch] = M_COAST;
                m_duty_now[ch] = 0; m_duty_next[ch] = 0;
                e_hi[ch] = 0; e_lo[ch] = 0; e_en[ch] = 0;
            end
            return;
        end
        for (int ch = 0; ch < 2; ch++) begin
            e_hi[ch] = (m_mode[ch] == M_FWD) || (m_mode[ch] == M_BRAKE);
            e_lo[ch] = (m_mode[ch] == M_REV) || (m_mode[ch] == M_BRAKE);
            e_en[ch] = (m_mode[ch] == M_BRAKE) ||
                       (((m_mode[ch] == M_FWD) || (m_mode[ch] == M_REV)) && (m_cnt < m_duty_now[ch]));
        end
        boundary = (m_cnt == PER - 1);
        m_cnt = (m_cnt + 1) % PER;
        for (int ch = 0; ch < 2; ch++) begin
            took   = cmd_valid && !estop && (m_mode[ch] != M_DEAD) && (int'(cmd_ch) == ch);
            loaded = 0;
            if (estop) begin
                m_mode[ch] = M_COAST;
            end else if (took) begin
                if (cmd_dir == 2'b00) m_mode[ch] = M_COAST;
                else if (cmd_dir == 2'b11) m_mode[ch] = M_BRAKE;
                else begin
                    want = (cmd_dir == 2'b01) ? M_FWD : M_REV;
                    m_duty_next[ch] = int'(cmd_duty);
                    if ((m_mode[ch] == M_FWD || m_mode[ch] == M_REV) && m_mode[ch] != want && DT > 0) begin
                        m_mode[ch] = M_DEAD; m_left[ch] = DT; m_tgt[ch] = want;
                    end else begin
                        if (m_mode[ch] == M_COAST || m_mode[ch] == M_BRAKE) begin
                            m_duty_now[ch] = int'(cmd_duty); loaded = 1;
                        end
                        m_mode[ch] = want;
                    end
                end
            end else if (m_mode[ch] == M_DEAD) begin
                m_left[ch]--;
                if (m_left[ch] == 0) begin
                    m_mode[ch] = m_tgt[ch];
                    m_duty_now[ch] = m_duty_next[ch];
                    loaded = 1;
                end
            end
            if (boundary && !loaded) m_duty_now[ch] = m_duty_next[ch];
        end
    endfunction

    always @(posedge clk) begin
        model_step();
        #2;
        if (model_on) begin
            chk("model_in1", drv_in1, e_hi[0]);
            chk("model_in2", drv_in2, e_lo[0]);
            chk("model_enA", drv_enA, e_en[0]);
            chk("model_in3", drv_in3, e_hi[1]);
            chk("model_in4", drv_in4, e_lo[1]);
            chk("model_enB", drv_enB, e_en[1]);
            chk("model_busy_a", busy_a, m_mode[0] == M_DEAD);
            chk("model_busy_b", busy_b, m_mode[1] == M_DEAD);
            chk("model_ready", cmd_ready, !estop && (m_mode[int'(cmd_ch)] != M_DEAD));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic ch, input logic [1:0] dir, input logic [W-1:0] duty);
        cmd_ch = ch; cmd_dir = dir; cmd_duty = duty; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic         ch;
        logic [1:0]   dir;
        logic [W-1:0] duty;
        logic         exp_hi;
        logic         exp_lo;
        int           exp_en;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, a_nz, acc_k, first_low, highs, ok, bad;
        bit drop;
        logic [15:0] pat1, pat2;

        vecs[0] = '{1'b0, 2'b01, 4'd4,  1'b1, 1'b0, 4};
        vecs[1] = '{1'b0, 2'b10, 4'd9,  1'b0, 1'b1, 9};
        vecs[2] = '{1'b1, 2'b01, 4'd7,  1'b1, 1'b0, 7};
        vecs[3] = '{1'b1, 2'b10, 4'd1,  1'b0, 1'b1, 1};
        vecs[4] = '{1'b0, 2'b11, 4'd5,  1'b1, 1'b1, 16};
        vecs[5] = '{1'b1, 2'b00, 4'd8,  1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, 2'b01, 4'd0,  1'b1, 1'b0, 0};
        vecs[7] = '{1'b0, 2'b01, 4'd15, 1'b1, 1'b0, 15};
        vecs[8] = '{1'b1, 2'b11, 4'd0,  1'b1, 1'b1, 16};

        // Reset state
        tick(); tick();
        model_on = 1'b1;
        chk("reset_drv", {drv_in1, drv_in2, drv_in3, drv_in4, drv_enA, drv_enB}, 6'b0);
        chk("reset_busy", {busy_a, busy_b}, 2'b00);
        chk("reset_ready", cmd_ready, 1'b1);
        rst = 1'b0;

        // Table: one command from reset, then one full PWM period observed
        for (int i = 0; i < 9; i++) begin
            int en_cnt, other_cnt, dir_ok;
            do_reset();
            send(vecs[i].ch, vecs[i].dir, vecs[i].duty);
            tick();
            en_cnt = 0; other_cnt = 0; dir_ok = 0;
            for (int s = 0; s < PER; s++) begin
                if (vecs[i].ch == 1'b0) begin
                    en_cnt += drv_enA; other_cnt += drv_enB + drv_in3 + drv_in4;
                    dir_ok += ({drv_in1, drv_in2} == {vecs[i].exp_hi, vecs[i].exp_lo});
                end else begin
                    en_cnt += drv_enB; other_cnt += drv_enA + drv_in1 + drv_in2;
                    dir_ok += ({drv_in3, drv_in4} == {vecs[i].exp_hi, vecs[i].exp_lo});
                end
                tick();
            end
            chk($sformatf("vec%0d_en_count", i), en_cnt, vecs[i].exp_en);
            chk($sformatf("vec%0d_dir_lines", i), dir_ok, PER);
            chk($sformatf("vec%0d_other_idle", i), other_cnt, 0);
        end

        // Duty change mid-period takes effect at the next period boundary
        do_reset();
        send(1'b0, 2'b01, 4'd12);
        pat1 = '0; pat2 = '0;
        for (int j = 1; j <= 47; j++) begin
            tick();
            if (j >= 16 && j <= 31) pat1[j % 16] = drv_enA;
            if (j >= 32) pat2[j % 16] = drv_enA;
            if (j == 19) begin cmd_ch = 1'b0; cmd_dir = 2'b01; cmd_duty = 4'd6; cmd_valid = 1'b1; end
            if (j == 20) cmd_valid = 1'b0;
        end
        chk("duty12_period_pattern", pat1, 16'h0FFF);
        chk("duty6_period_pattern", pat2, 16'h003F);

        // FWD -> REV reversal with dead-time, other channel and held command
        do_reset();
        send(1'b0, 2'b01, 4'd8);
        tick(); tick(); tick();
        send(1'b0, 2'b10, 4'd5);
        chk("dead_busy_a", busy_a, 1'b1);
        chk("dead_ready_a", cmd_ready, 1'b0);
        busy_cnt = busy_a;
        cmd_ch = 1'b1; cmd_dir = 2'b01; cmd_duty = 4'd10; cmd_valid = 1'b1;
        #1;
        chk("dead_ready_b", cmd_ready, 1'b1);
        tick();
        cmd_ch = 1'b0; cmd_dir = 2'b10; cmd_duty = 4'd3; cmd_valid = 1'b1;
        #1;
        a_nz = 0; acc_k = -1; drop = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) begin
                tick();
                if (drop) begin cmd_valid = 1'b0; drop = 0; end
            end
            busy_cnt += busy_a;
            if (k <= 3) a_nz += drv_in1 + drv_in2 + drv_enA;
            if (k == 2) chk("dead_b_accepted", {drv_in3, drv_in4}, 2'b10);
            if (k == 4) chk("rev_after_dead", {drv_in1, drv_in2}, 2'b01);
            if (cmd_valid && cmd_ready && acc_k < 0) begin drop = 1; acc_k = k; end
        end
        cmd_valid = 1'b0;
        chk("dead_busy_cycles", busy_cnt, DT);
        chk("dead_a_idle", a_nz, 0);
        chk("held_cmd_accept_point", acc_k, 3);

        // BRAKE then COAST on channel B
        send(1'b1, 2'b11, 4'd2);
        tick();
        ok = 0;
        for (int s = 0; s < PER; s++) begin
            ok += drv_in3 & drv_in4 & drv_enB;
            tick();
        end
        chk("brake_b_all_on", ok, PER);
        send(1'b1, 2'b00, 4'd9);
        tick();
        chk("coast_b_off", {drv_in3, drv_in4, drv_enB}, 3'b000);

        // estop during channel A dead-time
        do_reset();
        send(1'b0, 2'b01, 4'd8);
        send(1'b1, 2'b01, 4'd5);
        send(1'b0, 2'b10, 4'd5);
        estop = 1'b1;
        #1;
        chk("estop_ready_a", cmd_ready, 1'b0);
        tick();
        cmd_ch = 1'b1;
        #1;
        chk("estop_ready_b", cmd_ready, 1'b0);
        tick();
        chk("estop_drv_off", {drv_in1, drv_in2, drv_in3, drv_in4, drv_enA, drv_enB}, 6'b0);
        chk("estop_busy", {busy_a, busy_b}, 2'b00);
        estop = 1'b0;
        bad = 0;
        for (int s = 0; s < 20; s++) begin
            tick();
            bad += drv_in1 + drv_in2 + drv_in3 + drv_in4 + drv_enA + drv_enB;
        end
        chk("estop_stays_coast", bad, 0);
        send(1'b0, 2'b01, 4'd4);
        tick();
        chk("estop_new_cmd", {drv_in1, drv_in2}, 2'b10);

        // rst mid-dead-time and mid-PWM, then counter restart check with duty 15
        do_reset();
        send(1'b1, 2'b01, 4'd9);
        send(1'b0, 2'b01, 4'd7);
        tick(); tick();
        send(1'b0, 2'b10, 4'd7);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_drv_off", {drv_in1, drv_in2, drv_in3, drv_in4, drv_enA, drv_enB}, 6'b0);
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        rst = 1'b0;
        send(1'b0, 2'b01, 4'd15);
        first_low = -1; highs = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (!drv_enA && first_low < 0) first_low = j;
            if (j <= 16) highs += drv_enA;
        end
        chk("rst_cnt_restart", first_low, 15);
        chk("duty15_highs", highs, 15);

        // Randomized traffic against the model
        cmd_valid = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            bit acc;
            int r;
            #1;
            acc = cmd_valid && cmd_ready && !rst;
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (estop) estop = ($urandom_range(0, 3) != 0);
            else       estop = ($urandom_range(0, 59) == 0);
            if (acc || !cmd_valid) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                cmd_ch    = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 9);
                if (r < 4)      cmd_dir = 2'b01;
                else if (r < 8) cmd_dir = 2'b10;
                else if (r == 8) cmd_dir = 2'b00;
                else            cmd_dir = 2'b11;
                cmd_duty = 4'($urandom_range(0, PER - 1));
            end
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
